// File: rtl/matmul_result_display_pkg.sv
// Shared definitions for the matrix-multiply result display: FSM encoding,
// blank/off patterns, the hex digit segment table and a counter-width helper.
package matmul_result_display_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StShow    = 2'd2
    } state_e;

    // Segments are g..a (bit6..bit0), active-low.
    localparam logic [6:0] SegBlank = 7'h7F;
    localparam logic [3:0] AnOff    = 4'hF;

    // Indexed by the hex value of the digit; element 0 is the rightmost entry.
    localparam logic [15:0][6:0] SegHex = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_result_display_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern (g..a).
module matmul_result_display_hex_to_7seg
    import matmul_result_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Table lookup; every nibble value has a defined glyph.
    always_comb begin
        seg_n = SegHex[nibble];
    end

endmodule

// File: rtl/matmul_result_display.sv
// Captures one full result set from the matrix-multiply core, then cycles
// through it on a 4-digit multiplexed seven-segment display.
// Digits [3:2] show the result index, digits [1:0] the result value, in hex.
module matmul_result_display
    import matmul_result_display_pkg::*;
#(
    parameter int unsigned N_RESULTS      = 9,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned HOLD_CYCLES    = 50000000,
    parameter int unsigned REFRESH_CYCLES = 50000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_i,
    input  logic              res_valid_i,
    input  logic [DATA_W-1:0] res_data_i,
    output logic [6:0]        SEG_N,
    output logic [3:0]        AN_N,
    output logic              done_o,
    output logic              overflow_o
);

    localparam int unsigned IdxW  = cnt_width(N_RESULTS);
    // Write pointer must also represent N_RESULTS once the set is complete.
    localparam int unsigned WrW   = $clog2(N_RESULTS + 1);
    localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);
    localparam int unsigned RefW  = cnt_width(REFRESH_CYCLES);

    localparam logic [WrW-1:0]   LastSlot = WrW'(N_RESULTS - 1);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(N_RESULTS - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [RefW-1:0]  RefLast  = RefW'(REFRESH_CYCLES - 1);

    state_e            state_q;
    logic [WrW-1:0]    wr_ptr_q;
    logic [IdxW-1:0]   rd_idx_q;
    logic [HoldW-1:0]  hold_cnt_q;
    logic [RefW-1:0]   ref_cnt_q;
    logic [1:0]        dig_sel_q;
    logic              done_q;
    logic              overflow_q;
    logic [6:0]        seg_q;
    logic [3:0]        an_q;

    // Plain register array: read asynchronously by rd_idx, so not a RAM.
    logic [DATA_W-1:0] buf_q [N_RESULTS];

    logic [IdxW-1:0]   wr_idx;
    logic [7:0]        idx8;
    logic [7:0]        val8;
    logic [7:0]        cnt8;
    logic [3:0]        nibble;
    logic              blank;
    logic [6:0]        seg_hex;
    logic [6:0]        seg_d;
    logic [3:0]        an_d;

    // Only slots below N_RESULTS are ever written, so the low bits suffice.
    assign wr_idx = wr_ptr_q[IdxW-1:0];

    // Control FSM: capture sequencing, show-mode hold timer and index rotation.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_idx_q   <= '0;
            hold_cnt_q <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (start_i) begin
            // A new run wins over any same-cycle result strobe.
            state_q    <= StCapture;
            wr_ptr_q   <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                end
                StCapture: begin
                    if (res_valid_i) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        if (wr_ptr_q == LastSlot) begin
                            state_q    <= StShow;
                            rd_idx_q   <= '0;
                            hold_cnt_q <= '0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                StShow: begin
                    if (res_valid_i) begin
                        overflow_q <= 1'b1;
                    end
                    if (hold_cnt_q == HoldLast) begin
                        hold_cnt_q <= '0;
                        rd_idx_q   <= (rd_idx_q == LastIdx) ? '0 : rd_idx_q + 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Result buffer write; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if ((state_q == StCapture) && res_valid_i && !start_i) begin
            buf_q[wr_idx] <= res_data_i;
        end
    end

    // Free-running anode scan: dig_sel advances once per refresh period.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ref_cnt_q <= '0;
            dig_sel_q <= 2'd0;
        end else if (ref_cnt_q == RefLast) begin
            ref_cnt_q <= '0;
            dig_sel_q <= dig_sel_q + 2'd1;
        end else begin
            ref_cnt_q <= ref_cnt_q + 1'b1;
        end
    end

    // Pick the nibble for the scanned digit; blank digits that show nothing.
    always_comb begin
        idx8   = 8'(rd_idx_q);
        val8   = 8'(buf_q[rd_idx_q]);
        cnt8   = 8'(wr_ptr_q);
        nibble = 4'h0;
        blank  = 1'b1;
        case (state_q)
            StCapture: begin
                // Capture count on the two right digits only.
                blank  = dig_sel_q[1];
                nibble = dig_sel_q[0] ? cnt8[7:4] : cnt8[3:0];
            end
            StShow: begin
                blank = 1'b0;
                case (dig_sel_q)
                    2'd0:    nibble = val8[3:0];
                    2'd1:    nibble = val8[7:4];
                    2'd2:    nibble = idx8[3:0];
                    default: nibble = idx8[7:4];
                endcase
            end
            default: begin
            end
        endcase
    end

    matmul_result_display_hex_to_7seg u_hex_to_7seg (
        .nibble (nibble),
        .seg_n  (seg_hex)
    );

    // Anode and segment next values come from the same scan slot.
    always_comb begin
        an_d  = AnOff;
        seg_d = SegBlank;
        if (!blank) begin
            an_d  = ~(4'b0001 << dig_sel_q);
            seg_d = seg_hex;
        end
    end

    // Segments and anodes registered together so they switch on one edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seg_q <= SegBlank;
            an_q  <= AnOff;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign SEG_N      = seg_q;
    assign AN_N       = an_q;
    assign done_o     = done_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_matmul_result_display.sv
// Directed bench for matmul_result_display with short hold/refresh periods.
module tb_matmul_result_display;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start_i = 1'b0;
    logic       res_valid_i = 1'b0;
    logic [7:0] res_data_i = 8'h00;
    logic [6:0] SEG_N;
    logic [3:0] AN_N;
    logic       done_o;
    logic       overflow_o;

    int n_vec = 0;
    int n_err = 0;
    int show_j = 0;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [7:0] vals [9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    bit seen [9];

    matmul_result_display #(
        .N_RESULTS      (9),
        .DATA_W         (8),
        .HOLD_CYCLES    (4),
        .REFRESH_CYCLES (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start_i     (start_i),
        .res_valid_i (res_valid_i),
        .res_data_i  (res_data_i),
        .SEG_N       (SEG_N),
        .AN_N        (AN_N),
        .done_o      (done_o),
        .overflow_o  (overflow_o)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        return seg_tab[n];
    endfunction

    // Every step lands on a falling edge; show_j counts edges since SHOW entry.
    task automatic tick();
        @(negedge CLK);
        show_j++;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] d);
        res_valid_i = 1'b1;
        res_data_i  = d;
        tick();
        res_valid_i = 1'b0;
    endtask

    // In CAPTURE the right digits show the count and the left digits stay dark.
    task automatic check_count(input int exp_cnt, input string tag);
        bit saw0;
        bit saw1;
        logic [6:0] e0;
        logic [6:0] e1;
        saw0 = 1'b0;
        saw1 = 1'b0;
        e0 = seg_of(4'(exp_cnt));
        e1 = seg_of(4'(exp_cnt >> 4));
        for (int s = 0; s < 12 && !(saw0 && saw1); s++) begin
            tick();
            if (AN_N == 4'hE && !saw0) begin
                saw0 = 1'b1;
                n_vec++;
                if (SEG_N !== e0) begin
                    n_err++;
                    $display("FAIL %s count_lo: seg=%h want %h", tag, SEG_N, e0);
                end
            end else if (AN_N == 4'hD && !saw1) begin
                saw1 = 1'b1;
                n_vec++;
                if (SEG_N !== e1) begin
                    n_err++;
                    $display("FAIL %s count_hi: seg=%h want %h", tag, SEG_N, e1);
                end
            end else if (AN_N != 4'hF && AN_N != 4'hE && AN_N != 4'hD) begin
                n_vec++;
                n_err++;
                $display("FAIL %s capture_anode: an=%h want E, D or F", tag, AN_N);
            end
        end
        if (!(saw0 && saw1)) begin
            n_vec++;
            n_err++;
            $display("FAIL %s count_timeout: digit0 seen=%0d digit1 seen=%0d want 1 1",
                     tag, saw0, saw1);
        end
    endtask

    // In SHOW the index advances every 4 edges; allow one edge of display delay.
    task automatic check_show(input int n, input string tag);
        int ca;
        int cb;
        logic [6:0] ea;
        logic [6:0] eb;
        for (int s = 0; s < n; s++) begin
            tick();
            ca = (show_j / 4) % 9;
            cb = ((show_j - 1) / 4) % 9;
            case (AN_N)
                4'hE: begin ea = seg_of(vals[ca][3:0]); eb = seg_of(vals[cb][3:0]); end
                4'hD: begin ea = seg_of(vals[ca][7:4]); eb = seg_of(vals[cb][7:4]); end
                4'hB: begin ea = seg_of(4'(ca)); eb = seg_of(4'(cb)); end
                4'h7: begin ea = seg_of(4'(ca >> 4)); eb = seg_of(4'(cb >> 4)); end
                default: begin ea = 7'h7F; eb = 7'h7F; end
            endcase
            n_vec++;
            if (AN_N != 4'hE && AN_N != 4'hD && AN_N != 4'hB && AN_N != 4'h7) begin
                n_err++;
                $display("FAIL %s show_anode: an=%h want one-hot-low", tag, AN_N);
            end else if (SEG_N !== ea && SEG_N !== eb) begin
                n_err++;
                $display("FAIL %s show_digit: j=%0d an=%h seg=%h want %h or %h",
                         tag, show_j, AN_N, SEG_N, ea, eb);
            end else if (AN_N == 4'hB) begin
                if (SEG_N === ea) seen[ca] = 1'b1;
                else seen[cb] = 1'b1;
            end
        end
    endtask

    task automatic fill_set();
        for (int i = 0; i < 9; i++) strobe(vals[i]);
        show_j = 0;
    endtask

    task automatic test_reset();
        tick();
        n_vec++;
        if (SEG_N !== 7'h7F || AN_N !== 4'hF) begin
            n_err++;
            $display("FAIL reset_disp: seg=%h an=%h want 7f f", SEG_N, AN_N);
        end
        n_vec++;
        if (done_o !== 1'b0 || overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: done=%b ovf=%b want 0 0", done_o, overflow_o);
        end
        RST = 1'b0;
        for (int s = 0; s < 10; s++) begin
            tick();
            n_vec++;
            if (AN_N !== 4'hF) begin
                n_err++;
                $display("FAIL idle_anode: an=%h want f", AN_N);
            end
        end
        pulse_start();
        fill_set();
        tick();
        tick();
        n_vec++;
        if (done_o !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_done: done=%b want 1", done_o);
        end
        // Assert reset between edges and look before the next rising edge.
        #2 RST = 1'b1;
        #1;
        n_vec++;
        if (SEG_N !== 7'h7F || AN_N !== 4'hF || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: seg=%h an=%h done=%b want 7f f 0", SEG_N, AN_N, done_o);
        end
        tick();
        RST = 1'b0;
    endtask

    task automatic test_capture();
        pulse_start();
        check_count(0, "cap");
        for (int i = 0; i < 8; i++) begin
            strobe(vals[i]);
            check_count(i + 1, "cap");
        end
        n_vec++;
        if (done_o !== 1'b0) begin
            n_err++;
            $display("FAIL done_early: done=%b want 0", done_o);
        end
        strobe(vals[8]);
        show_j = 0;
        n_vec++;
        if (done_o !== 1'b1) begin
            n_err++;
            $display("FAIL done_rise: done=%b want 1", done_o);
        end
    endtask

    task automatic test_cycle_wrap();
        for (int i = 0; i < 9; i++) seen[i] = 1'b0;
        check_show(96, "cycle");
        for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (!seen[i]) begin
                n_err++;
                $display("FAIL index_seen: index %0d seen=0 want 1", i);
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] prev;
        logic [3:0] exp_an;
        bit found;
        found = 1'b0;
        prev = AN_N;
        for (int s = 0; s < 20 && !found; s++) begin
            tick();
            if (prev == 4'h7 && AN_N == 4'hE) found = 1'b1;
            prev = AN_N;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL scan_sync: an=%h want 7 then e within 20 cycles", AN_N);
        end else begin
            for (int s = 1; s < 8; s++) begin
                tick();
                exp_an = ~(4'b0001 << (s / 2));
                n_vec++;
                if (AN_N !== exp_an) begin
                    n_err++;
                    $display("FAIL scan_step: step %0d an=%h want %h", s, AN_N, exp_an);
                end
            end
        end
    endtask

    task automatic test_overflow();
        n_vec++;
        if (overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: ovf=%b want 0", overflow_o);
        end
        res_valid_i = 1'b1;
        res_data_i  = 8'hEE;
        check_show(1, "ovf");
        res_valid_i = 1'b0;
        n_vec++;
        if (overflow_o !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: ovf=%b want 1", overflow_o);
        end
        check_show(80, "ovf_keep");
        pulse_start();
        n_vec++;
        if (overflow_o !== 1'b0 || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL restart_flags: ovf=%b done=%b want 0 0", overflow_o, done_o);
        end
    endtask

    task automatic test_collision();
        strobe(8'h33);
        check_count(1, "pre_coll");
        start_i     = 1'b1;
        res_valid_i = 1'b1;
        res_data_i  = 8'hAB;
        tick();
        start_i     = 1'b0;
        res_valid_i = 1'b0;
        check_count(0, "coll");
        strobe(8'h44);
        check_count(1, "post_coll");
    endtask

    task automatic test_abort();
        pulse_start();
        for (int i = 0; i < 5; i++) strobe(vals[i]);
        check_count(5, "abort");
        #2 RST = 1'b1;
        tick();
        RST = 1'b0;
        n_vec++;
        if (done_o !== 1'b0 || AN_N !== 4'hF) begin
            n_err++;
            $display("FAIL abort_idle: done=%b an=%h want 0 f", done_o, AN_N);
        end
        strobe(8'h5A);
        for (int s = 0; s < 10; s++) begin
            tick();
            n_vec++;
            if (AN_N !== 4'hF || overflow_o !== 1'b0) begin
                n_err++;
                $display("FAIL abort_stay_idle: an=%h ovf=%b want f 0", AN_N, overflow_o);
            end
        end
        pulse_start();
        check_count(0, "abort_restart");
    endtask

    initial begin
        test_reset();
        test_capture();
        test_cycle_wrap();
        test_scan();
        test_overflow();
        test_collision();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
